// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full-subtractor cell: diff = a - b - borrowIn, with outgoing borrow.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic borrowIn,
  output logic diff,
  output logic borrowOut
);

  assign diff      = a ^ b ^ borrowIn;
  assign borrowOut = (~a & b) | (~(a ^ b) & borrowIn);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full_sub cell processes one bit per cycle, LSB first,
// producing diff = a - b (mod 2^WIDTH) and the final borrow after WIDTH cycles.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-2:0]   r_res;
  logic               r_borrow;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow_out;

  logic               w_dbit;
  logic               w_bout;
  logic [WIDTH-1:0]   w_res_nxt;

  full_sub u_cell (
    .a         (r_a_sh[0]),
    .b         (r_b_sh[0]),
    .borrowIn  (r_borrow),
    .diff      (w_dbit),
    .borrowOut (w_bout)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  assign w_res_nxt = {w_dbit, r_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_res        <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state  <= IDLE;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res    <= w_res_nxt[WIDTH-1:1];
          r_borrow <= w_bout;
          // Result outputs only change here, so they hold steady through the next RUN.
          if (r_cnt == LAST) begin
            r_state      <= DONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_diff       <= w_res_nxt;
            r_borrow_out <= w_bout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at WIDTH=8: vector table, corner sequences, random regression.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int n_pass = 0;
  int n_tot  = 0;
  bit overlap_seen = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap_seen = 1'b1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference: 9-bit unsigned difference; bit W is the borrow.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  // Issue one operation from a negedge and wait (bounded) for done.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output logic [W-1:0] od, output logic ob,
                        output int lat, output int bcnt, output bit tmo);
    int n;
    start = 1'b1; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0;
    n = 1; bcnt = 0; tmo = 1'b0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      n++;
    end
    tmo = !done;
    lat = n;
    od  = diff;
    ob  = borrow_out;
  endtask

  initial begin
    logic [W-1:0] od;
    logic         ob;
    logic [W:0]   exp9;
    int           lat, bcnt, dcnt, rnd_bad;
    bit           tmo, held_ok, quiet;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[3] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[4] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
    vecs[5] = '{8'h01, 8'h00, 8'h01, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_diff", 32'(diff), 0);
    chk("reset_borrow", 32'(borrow_out), 0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, od, ob, lat, bcnt, tmo);
      chk($sformatf("vec%0d_timeout", i), 32'(tmo), 0);
      chk($sformatf("vec%0d_diff", i), 32'(od), 32'(vecs[i].d));
      chk($sformatf("vec%0d_borrow", i), 32'(ob), 32'(vecs[i].bo));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 9);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 8);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
    end

    // start re-asserted during RUN must be ignored
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h22;
    repeat (2) @(negedge clk);
    start = 1'b0;
    dcnt = 0; od = '0; ob = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (done) begin dcnt++; od = diff; ob = borrow_out; end
      @(negedge clk);
    end
    chk("run_start_done_count", 32'(dcnt), 1);
    chk("run_start_diff", 32'(od), 32'h1E);
    chk("run_start_borrow", 32'(ob), 0);

    // back-to-back: start in the DONE cycle, previous result held through RUN
    run_op(8'h00, 8'h01, od, ob, lat, bcnt, tmo);
    chk("b2b_first_diff", 32'(od), 32'hFF);
    start = 1'b1; a = 8'h80; b = 8'h7F;
    @(negedge clk);
    start = 1'b0;
    lat = 1; held_ok = 1'b1;
    while (!done && lat < 40) begin
      if (diff !== 8'hFF || borrow_out !== 1'b1) held_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("b2b_held", 32'(held_ok), 1);
    chk("b2b_latency", 32'(lat), 9);
    chk("b2b_diff", 32'(diff), 32'h01);
    chk("b2b_borrow", 32'(borrow_out), 0);

    // reset in RUN cycle 4, with start held alongside reset
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_borrow", 32'(borrow_out), 0);
    quiet = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (done || busy) quiet = 1'b0;
      @(negedge clk);
    end
    chk("rst_no_done", 32'(quiet), 1);

    // random regression
    rnd_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      exp9 = model(ra, rb);
      run_op(ra, rb, od, ob, lat, bcnt, tmo);
      n_tot++;
      if ({ob, od} === exp9 && !tmo && lat == 9) n_pass++;
      else if (rnd_bad++ < 10)
        $display("FAIL rand a=0x%0h b=0x%0h: got 0x%0h lat %0d expected 0x%0h lat 9",
                 ra, rb, {ob, od}, lat, exp9);
      if (i % 3 == 0) @(negedge clk);
    end

    chk("busy_done_exclusive", 32'(overlap_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
